conv_sequencer: RTL
===================

// Module: conv_sequencer
// PURPOSE
//  Sequences one MSDAP output sample for one channel's shift-add convolution datapath: walks the 16 rj
//  segments, issues rj/coeff/data memory addresses, and drives accumulator strobes (clr/add/sub/shift).
//  Started by the control unit once per accepted input sample; one instance per channel (L, R).
//  Memories are combinational-read: data_out is valid in the same cycle as its read_addr.
// PARAMETERS
//  RJ_COUNT         16  segments per output; rj_addr width = clog2(RJ_COUNT)
//  RJ_WIDTH         16  rj word width; only the low COEFF_ADDR_BITS+1 bits form the count
//  COEFF_ADDR_BITS  9   coeff memory address width (512 entries)
//  COEFF_WIDTH      16  coeff word width: bit SIGN_BIT is sign, bits [DATA_ADDR_BITS-1:0] are lag m
//  SIGN_BIT         8   coeff sign bit position (1 = subtract)
//  DATA_ADDR_BITS   8   data memory address width (256-sample circular buffer)
// PORTS
//  sclk        in   1                clock; all state changes on rising edge
//  reset       in   1                synchronous, active-high; returns block to IDLE
//  start_conv  in   1                1-cycle pulse: newest sample written at sample_ptr
//  sample_ptr  in   DATA_ADDR_BITS   data memory address of newest sample x[n]
//  hist_clr    in   1                clear sample history (sleep exit / zero-run restart)
//  rj_in       in   RJ_WIDTH         rj memory read data
//  coeff_in    in   COEFF_WIDTH      coeff memory read data
//  rj_addr     out  clog2(RJ_COUNT)  rj memory read address
//  coeff_addr  out  COEFF_ADDR_BITS  coeff memory read address
//  data_addr   out  DATA_ADDR_BITS   data memory read address
//  acc_clr     out  1                zero accumulator
//  acc_en      out  1                accumulate one term this cycle
//  acc_sub     out  1                with acc_en: subtract operand instead of add
//  data_zero   out  1                with acc_en: operand forced to 0 (x[n-m], n<m)
//  acc_shift   out  1                arithmetic right-shift accumulator by 1
//  done        out  1                1-cycle pulse: accumulator holds final output
//  busy        out  1                high from cycle after start_conv accepted through DONE
//  overrun     out  1                sticky: start_conv seen while busy
//  coeff_ovf   out  1                sticky: coefficient address passed 2^COEFF_ADDR_BITS-1
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, hist_cnt, remaining, latched ptr = 0. Sticky flags clear only on reset.
//  FSM IDLE -> LOAD_RJ -> (TERM)* -> SHIFT -> ... -> DONE -> IDLE. Outputs are registered per state.
//  IDLE: busy=0. start_conv=1: latch sample_ptr, rj_addr<=0, coeff_addr<=0, acc_clr=1 this cycle, go LOAD_RJ.
//  LOAD_RJ: remaining<=rj_in[COEFF_ADDR_BITS:0]; if 0 go SHIFT, else go TERM.
//  TERM (one coefficient per cycle): m=coeff_in[DATA_ADDR_BITS-1:0];
//   data_addr=(ptr-m) mod 2^DATA_ADDR_BITS; acc_en=1; acc_sub=coeff_in[SIGN_BIT]; data_zero=(m>hist_cnt).
//   coeff_addr<=coeff_addr+1 (wraps mod 2^COEFF_ADDR_BITS); wrap from max sets coeff_ovf, sequence continues.
//   remaining<=remaining-1; when remaining==1 go SHIFT.
//  SHIFT: acc_shift=1 one cycle; if rj_addr==RJ_COUNT-1 go DONE, else rj_addr<=rj_addr+1, go LOAD_RJ.
//  DONE: done=1 one cycle; hist_cnt<=hist_cnt+1 saturating at 2^DATA_ADDR_BITS-1; go IDLE.
//  Latency: start_conv at edge 0 -> done high in cycle 2*RJ_COUNT+1+S, S=sum of rj counts (33+S default).
//  Strobes mutually exclusive: at most one of acc_clr/acc_en/acc_shift/done per cycle.
//  data_addr/acc_sub/data_zero are 0 outside TERM; coeff_addr/rj_addr hold between uses.
//  start_conv while busy (including DONE cycle): ignored, overrun<=1, running sequence unaffected.
//  hist_clr: hist_cnt<=0 next edge, any state; wins over DONE increment in same cycle;
//   with start_conv in IDLE both take effect (sequence runs with hist_cnt=0).
//  Reset mid-sequence: IDLE next edge, no done pulse, all strobes low.
// TESTING
//  T1 all rj=0, start_conv -> acc_clr at cycle 0, 16 acc_shift pulses, no acc_en, done at cycle 33.
//  T2 rj[0]=3 others 0, coeff[0..2]=0x000,0x105,0x002, ptr=10, hist_cnt=255 -> TERM data_addr 10,5,8;
//     acc_sub 0,1,0; done at cycle 36.
//  T3 ptr=2, coeff lag 5, hist_cnt=255 -> data_addr=253 (wrap); after hist_clr, same term -> data_zero=1.
//  T4 start_conv pulsed at cycle 10 of a busy sequence -> overrun=1, done timing unchanged, stays set.
//  T5 rj counts summing to 514 -> coeff_addr wraps 511->0, coeff_ovf=1, done at cycle 33+514.
//  T6 reset asserted in TERM -> next cycle IDLE, busy=0, all strobes 0, no done; new start_conv runs T1 clean.

Source files
------------

// File: rtl/conv_sequencer.sv
// Per-channel shift-add convolution sequencer: walks the rj segments and issues
// rj/coeff/data read addresses plus accumulator strobes for one output sample.
module conv_sequencer #(
   parameter int RJ_COUNT        = 16,
   parameter int RJ_WIDTH        = 16,
   parameter int COEFF_ADDR_BITS = 9,
   parameter int COEFF_WIDTH     = 16,
   parameter int SIGN_BIT        = 8,
   parameter int DATA_ADDR_BITS  = 8
) (
   input  logic                        sclk,
   input  logic                        reset,
   input  logic                        start_conv,
   input  logic [DATA_ADDR_BITS-1:0]   sample_ptr,
   input  logic                        hist_clr,
   input  logic [RJ_WIDTH-1:0]         rj_in,
   input  logic [COEFF_WIDTH-1:0]      coeff_in,
   output logic [$clog2(RJ_COUNT)-1:0] rj_addr,
   output logic [COEFF_ADDR_BITS-1:0]  coeff_addr,
   output logic [DATA_ADDR_BITS-1:0]   data_addr,
   output logic                        acc_clr,
   output logic                        acc_en,
   output logic                        acc_sub,
   output logic                        data_zero,
   output logic                        acc_shift,
   output logic                        done,
   output logic                        busy,
   output logic                        overrun,
   output logic                        coeff_ovf
);

   localparam int RA_W  = $clog2(RJ_COUNT);
   localparam int REM_W = COEFF_ADDR_BITS + 1;
   localparam logic [RA_W-1:0] RJ_LAST = RA_W'(RJ_COUNT - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TERM, S_SHIFT, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic [RA_W-1:0]             rj_addr_q, rj_addr_d;
   logic [COEFF_ADDR_BITS-1:0]  coeff_addr_q, coeff_addr_d;
   logic [REM_W-1:0]            rem_q, rem_d;
   logic [DATA_ADDR_BITS-1:0]   ptr_q, ptr_d;
   logic [DATA_ADDR_BITS-1:0]   hist_q, hist_d;
   logic                        ovr_q, ovr_d;
   logic                        covf_q, covf_d;
   logic [DATA_ADDR_BITS-1:0]   lag;
   logic [REM_W-1:0]            rj_cnt;

   assign lag    = coeff_in[DATA_ADDR_BITS-1:0];
   assign rj_cnt = rj_in[COEFF_ADDR_BITS:0];

   // Upper word bits carry no meaning for sequencing.
   logic unused_bits;
   assign unused_bits = ^{rj_in[RJ_WIDTH-1:REM_W], coeff_in[COEFF_WIDTH-1:SIGN_BIT+1]};

   always_ff @(posedge sclk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rj_addr_q    <= '0;
         coeff_addr_q <= '0;
         rem_q        <= '0;
         ptr_q        <= '0;
         hist_q       <= '0;
         ovr_q        <= 1'b0;
         covf_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rj_addr_q    <= rj_addr_d;
         coeff_addr_q <= coeff_addr_d;
         rem_q        <= rem_d;
         ptr_q        <= ptr_d;
         hist_q       <= hist_d;
         ovr_q        <= ovr_d;
         covf_q       <= covf_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rj_addr_d    = rj_addr_q;
      coeff_addr_d = coeff_addr_q;
      rem_d        = rem_q;
      ptr_d        = ptr_q;
      hist_d       = hist_q;
      ovr_d        = ovr_q;
      covf_d       = covf_q;
      data_addr    = '0;
      acc_clr      = 1'b0;
      acc_en       = 1'b0;
      acc_sub      = 1'b0;
      data_zero    = 1'b0;
      acc_shift    = 1'b0;
      done         = 1'b0;

      if (state_q != S_IDLE && start_conv) ovr_d = 1'b1;

      case (state_q)
         S_IDLE: if (start_conv) begin
            ptr_d        = sample_ptr;
            rj_addr_d    = '0;
            coeff_addr_d = '0;
            acc_clr      = 1'b1;
            state_d      = S_LOAD;
         end
         S_LOAD: begin
            rem_d   = rj_cnt;
            state_d = (rj_cnt == '0) ? S_SHIFT : S_TERM;
         end
         S_TERM: begin
            // Lags beyond the recorded history reach before the first sample.
            data_addr    = ptr_q - lag;
            acc_en       = 1'b1;
            acc_sub      = coeff_in[SIGN_BIT];
            data_zero    = lag > hist_q;
            coeff_addr_d = coeff_addr_q + 1'b1;
            if (&coeff_addr_q) covf_d = 1'b1;
            rem_d        = rem_q - 1'b1;
            if (rem_q == REM_W'(1)) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            acc_shift = 1'b1;
            if (rj_addr_q == RJ_LAST) state_d = S_DONE;
            else begin
               rj_addr_d = rj_addr_q + 1'b1;
               state_d   = S_LOAD;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            if (!(&hist_q)) hist_d = hist_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (hist_clr) hist_d = '0;
   end

   assign busy       = (state_q != S_IDLE);
   assign rj_addr    = rj_addr_q;
   assign coeff_addr = coeff_addr_q;
   assign overrun    = ovr_q;
   assign coeff_ovf  = covf_q;

endmodule
